// File: rtl/fcpu_pkg.sv
// Shared CDB constants and beat layout.
// Used by the broadcaster and every reservation station.
package fcpu_pkg;

  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
  } cdb_t;

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Result-port and broadcast bundle of the CDB transmitter.
// slave is the broadcaster side, master the producer/observer side.
interface cdb_broadcaster_if #(
  parameter int N_SOURCES = 4,
  parameter int SRC_W     = $clog2(N_SOURCES)
);
  import fcpu_pkg::*;

  logic [N_SOURCES-1:0]       i_valid;
  logic [N_SOURCES*CDB_W-1:0] i_data;
  logic [N_SOURCES-1:0]       i_ready;
  logic                       cdb_valid;
  cdb_t                       cdb;
  logic [SRC_W-1:0]           o_grant;
  logic                       o_busy;

  modport slave (
    input  i_valid, i_data,
    output i_ready, cdb_valid, cdb,
    output o_grant, o_busy
  );

  modport master (
    output i_valid, i_data,
    input  i_ready, cdb_valid, cdb,
    input  o_grant, o_busy
  );

endinterface

// File: rtl/cdb_source_fifo.sv
// Per-source result buffer in front of the CDB arbiter.
// Pointers carry one extra wrap bit to tell full from empty.
module cdb_source_fifo #(
  parameter int DEPTH_W = 1,
  parameter int WIDTH   = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [2**DEPTH_W];
  logic [DEPTH_W:0] wptr;
  logic [DEPTH_W:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_W] != rptr[DEPTH_W])
              && (wptr[DEPTH_W-1:0] == rptr[DEPTH_W-1:0]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr[DEPTH_W-1:0]];

  // Advance pointers; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[DEPTH_W-1:0]] <= din;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit end: buffers FU results per source and
// broadcasts one beat per cycle under round-robin arbitration.
module cdb_broadcaster
  import fcpu_pkg::*;
#(
  parameter int N_SOURCES    = 4,
  parameter int FIFO_DEPTH_W = 1,
  parameter int SRC_W        = $clog2(N_SOURCES)
) (
  input logic             clk,
  input logic             rst,
  cdb_broadcaster_if.slave bus
);

  logic [N_SOURCES-1:0]            empty;
  logic [N_SOURCES-1:0]            full;
  logic [N_SOURCES-1:0]            push;
  logic [N_SOURCES-1:0]            pop;
  logic [N_SOURCES-1:0][CDB_W-1:0] head;

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] gnt;
  logic             any;

  logic             cdb_valid_q;
  cdb_t             cdb_q;
  logic [SRC_W-1:0] grant_q;

  assign bus.i_ready = ~full & {N_SOURCES{~rst}};
  assign push        = bus.i_valid & bus.i_ready;

  for (genvar g = 0; g < N_SOURCES; g++) begin : g_src
    cdb_source_fifo #(
      .DEPTH_W (FIFO_DEPTH_W),
      .WIDTH   (CDB_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .din   (bus.i_data[g*CDB_W +: CDB_W]),
      .pop   (pop[g]),
      .dout  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  // Pick the first non-empty head starting at rr_ptr.
  always_comb begin : arb
    int k;
    k   = 0;
    any = 1'b0;
    gnt = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= N_SOURCES) k = k - N_SOURCES;
      if (!any && !empty[k]) begin
        any = 1'b1;
        gnt = SRC_W'(k);
      end
    end
  end

  // Pop only the granted FIFO.
  always_comb begin
    pop = '0;
    for (int s = 0; s < N_SOURCES; s++) begin
      pop[s] = any && (gnt == SRC_W'(s));
    end
  end

  // Rotate priority past the winner; hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (any) begin
      if (gnt == SRC_W'(N_SOURCES - 1)) rr_ptr <= '0;
      else                              rr_ptr <= gnt + 1'b1;
    end
  end

  // Registered broadcast; payload holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      grant_q     <= '0;
    end else begin
      cdb_valid_q <= any;
      if (any) begin
        cdb_q   <= cdb_t'(head[gnt]);
        grant_q <= gnt;
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb       = cdb_q;
  assign bus.o_grant   = grant_q;
  assign bus.o_busy    = (|(~empty)) | cdb_valid_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: queue-based reference
// model predicts every beat; a negedge monitor compares.
module tb_cdb_broadcaster;
  import fcpu_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 1;
  localparam int DEPTH = 2 ** DW;

  typedef struct {
    int   src;
    cdb_t beat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_broadcaster_if #(.N_SOURCES(N)) bus ();

  cdb_broadcaster #(
    .N_SOURCES    (N),
    .FIFO_DEPTH_W (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0] vld;
  cdb_t         cur [N];

  // Pack per-source stimulus onto the bus.
  always_comb begin
    bus.i_data  = '0;
    bus.i_valid = vld;
    for (int s = 0; s < N; s++) begin
      bus.i_data[s*CDB_W +: CDB_W] = cur[s];
    end
  end

  cdb_t         mq [N][$];
  exp_t         exp_q [$];
  int           rr      = 0;
  bit           m_valid = 0;
  bit           started = 0;
  logic [N-1:0] acc     = '0;
  int           waitc [N];
  int           n_chk   = 0;
  int           n_err   = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic cdb_t rnd_item();
    cdb_t r;
    r.tag  = RSV_ID_W'($urandom);
    r.data = $urandom;
    return r;
  endfunction

  // Reference model: per-source queues, round-robin over them.
  initial begin : model
    logic [N-1:0] a;
    int s;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        exp_q.delete();
        rr      = 0;
        m_valid = 0;
        acc     = '0;
        started = 1;
      end else begin
        for (int i = 0; i < N; i++)
          a[i] = vld[i] && (mq[i].size() < DEPTH);
        m_valid = 0;
        for (int i = 0; i < N; i++) begin
          s = (rr + i) % N;
          if (!m_valid && mq[s].size() > 0) begin
            exp_q.push_back('{src: s, beat: mq[s].pop_front()});
            m_valid = 1;
            rr      = (s + 1) % N;
          end
        end
        for (int i = 0; i < N; i++)
          if (a[i]) mq[i].push_back(cur[i]);
        acc = a;
      end
    end
  end

  // Monitor: compare DUT outputs against the model each cycle.
  initial begin : monitor
    exp_t         e;
    logic [N-1:0] rdy;
    bit           busy;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
        if (bus.cdb_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t",
                     bus.cdb, $time);
          end else begin
            e = exp_q.pop_front();
            chk("cdb", 64'(bus.cdb), 64'(e.beat));
            chk("o_grant", 64'(bus.o_grant), 64'(e.src));
          end
        end
        busy = m_valid;
        for (int i = 0; i < N; i++) begin
          rdy[i] = !rst && (mq[i].size() < DEPTH);
          if (mq[i].size() > 0) busy = 1;
          if (bus.cdb_valid === 1'b1 && int'(bus.o_grant) == i)
            waitc[i] = 0;
          else if (mq[i].size() > 0)
            waitc[i]++;
          else
            waitc[i] = 0;
          chk("fairness", 64'(waitc[i] > N), 64'(0));
        end
        chk("i_ready", 64'(bus.i_ready), 64'(rdy));
        chk("o_busy", 64'(bus.o_busy), 64'(busy));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Directed scenarios followed by a random soak.
  initial begin : stim
    int sent1;
    int guard;
    vld = '0;
    for (int s = 0; s < N; s++) cur[s] = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();

    cur[2].tag  = 4'h5;
    cur[2].data = 32'hDEADBEEF;
    vld = 4'b0100;
    step();
    vld = '0;
    repeat (5) step();

    for (int s = 0; s < N; s++) begin
      cur[s].tag  = RSV_ID_W'(s + 1);
      cur[s].data = $urandom;
    end
    vld = 4'b1111;
    step();
    vld = '0;
    repeat (8) step();

    sent1 = 0;
    guard = 0;
    for (int s = 0; s < N; s++) cur[s] = rnd_item();
    cur[1].tag = '0;
    vld = 4'b1111;
    while (sent1 < 6 && guard < 200) begin
      step();
      guard++;
      for (int s = 0; s < N; s++)
        if (s != 1 && acc[s]) cur[s] = rnd_item();
      if (acc[1]) begin
        sent1++;
        cur[1].tag  = RSV_ID_W'(sent1);
        cur[1].data = $urandom;
        if (sent1 == 6) vld[1] = 1'b0;
      end
    end
    if (sent1 < 6) begin
      n_chk++;
      n_err++;
      $display("FAIL backpressure_timeout: got %0d expected 6", sent1);
    end
    vld = '0;
    repeat (12) step();

    for (int s = 0; s < N; s++) cur[s] = rnd_item();
    vld = 4'b0111;
    step();
    step();
    vld = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();

    for (int c = 0; c < 10000; c++) begin
      for (int s = 0; s < N; s++) begin
        if (acc[s] || !vld[s]) cur[s] = rnd_item();
        if (c < 5000) vld[s] = ($urandom_range(0, 3) != 0);
        else          vld[s] = ($urandom_range(0, 9) < 3);
      end
      step();
    end
    vld = '0;
    repeat (20) step();
    chk("drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Transmit end of the common data bus (CDB): collects completed results (tag + data) from N functional units.
- Buffers them per source and arbitrates round-robin.
- Drives exactly one broadcast per cycle on cdb_valid/cdb to every reservation station and the ROB.
- The CDB has no back-pressure, so every consumer must accept any beat this block drives.

Parameters:
- N_SOURCES, 4, number of functional-unit result ports (>=2).
- FIFO_DEPTH_W, 1, log2 of per-source buffer depth (default 2 entries).
- SRC_W, $clog2(N_SOURCES), width of the grant index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  N_SOURCES  per-source result valid.
- i_data  in  N_SOURCES*CDB_W  per-source {tag[RSV_ID_W], data[DATA_W]}; source s occupies bits s*CDB_W +: CDB_W.
- i_ready  out  N_SOURCES  per-source accept.
- cdb_valid  out  1  broadcast valid (registered).
- cdb  out  CDB_W  broadcast {tag, data}; tag in bits DATA_W +: RSV_ID_W (registered).
- o_grant  out  SRC_W  source index of the current broadcast (registered; debug/perf).
- o_busy  out  1  any buffer non-empty OR cdb_valid.

Behaviour:
- Reset (synchronous, active-high, while rst=1 at the edge):
  - All FIFOs emptied; rr_ptr=0.
  - cdb_valid=0, cdb=0, o_grant=0, o_busy=0.
  - i_ready forced to 0 while rst is high.
  - Reset mid-operation discards every buffered result; no partial broadcast occurs.
- Accept:
  - Source s transfers on an edge with i_valid[s] & i_ready[s].
  - i_ready[s] = ~full[s] & ~rst.
  - No pass-through when full: a simultaneous pop on a full FIFO does not raise i_ready in that cycle.
- Per-source FIFO:
  - 2**FIFO_DEPTH_W entries, first-in first-out.
  - Pointers are FIFO_DEPTH_W+1 bits and wrap naturally; full when the MSBs differ and the LSBs are equal.
  - A simultaneous push and pop on a non-empty, non-full FIFO keeps the count unchanged.
- Arbitration (combinational over FIFO heads):
  - Grant goes to the first non-empty source at index rr_ptr, rr_ptr+1, ... (mod N_SOURCES).
  - On a grant g: pop FIFO g, rr_ptr <= (g+1) mod N_SOURCES.
  - With no requests, rr_ptr holds.
- Output register:
  - On each edge: cdb_valid <= any_nonempty, cdb <= head[g], o_grant <= g.
  - When no request, cdb_valid <= 0 and cdb holds its last value.
  - Exactly one beat per cycle.
- Latency:
  - A result accepted at edge k is broadcast no earlier than after edge k+1, i.e. visible in the cycle after it is buffered.
  - Minimum latency is 2 edges from i_valid to the cdb_valid beat.
- Fairness:
  - Any non-empty source is granted within N_SOURCES consecutive cycles.
  - Sustained throughput is 1 beat/cycle total.
- Ordering: results from the same source are broadcast in acceptance order; there is no ordering guarantee across sources.
- Integrity:
  - Tag and data are never modified or merged.
  - No duplicate broadcast of a single accepted result; no result is lost except by reset.

Decomposition:
- fcpu_pkg holds RSV_ID_W, DATA_W, CDB_W (=RSV_ID_W+DATA_W) and a cdb_t packed struct {tag, data}.
- All reservation stations share these constants and cdb_t.
- One sub-module, cdb_source_fifo (params DEPTH_W, WIDTH), instantiated N_SOURCES times via generate.
- Arbiter and output register stay in cdb_broadcaster.

Test Plan:
- Reset then idle -> cdb_valid=0, o_busy=0, i_ready=4'b1111 from the first cycle after rst falls.
- Single source: source 2 sends {tag=4'h5, data=32'hDEADBEEF} at edge 0 -> at edge 1 buffered; after edge 2 (2 edges from i_valid), cdb_valid=1, cdb={4'h5, 32'hDEADBEEF}, o_grant=2 for exactly one cycle.
- All four sources send one result in the same cycle (tags 1..4), rr_ptr=0 -> broadcasts on 4 consecutive cycles in order src0, src1, src2, src3, no gaps; rr_ptr ends at 0.
- Back-pressure:
  - Source 1 holds i_valid for 6 cycles while sources 0, 2, 3 are saturated.
  - FIFO1 fills to 2 entries and i_ready[1]=0 until it is granted.
  - Source 1 is granted every 4th cycle; all 6 of its tags appear in order.
- Reset mid-operation: 3 FIFOs non-empty, assert rst for one cycle -> next cycle cdb_valid=0, o_busy=0; no buffered tag is ever broadcast afterwards.
- Random soak: 10k cycles of random i_valid, scoreboard per source -> every accepted {tag, data} is broadcast exactly once, per-source order is preserved, and the fairness bound of <= N_SOURCES cycles holds.
